// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: sequencer states, SYNC pattern
// and PID codes.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_WAITCRC,
    ST_EOP,
    ST_DONE,
    ST_REJECT
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // The PID travels with its own complement in the upper nibble as a check field.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/crc_tx_sequencer_counter.sv
// Generic up counter with clear priority over increment; wraps naturally at 2**W.
module counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         inc_cnt,
  input  logic         clr_cnt,
  output logic [W-1:0] up
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (inc_cnt) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign up = cnt_q;

endmodule

// File: rtl/crc_tx_sequencer.sv
// Serialises SYNC, PID and payload bytes LSB-first into the bit-serial CRC stage,
// then waits for the CRC tail, requests EOP and reports completion.
module crc_tx_sequencer #(
  parameter int MAX_BYTES  = 64,
  parameter int LEN_W      = 7,
  parameter int EOP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [3:0]       pkt_pid,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [7:0]       data_byte,
  input  logic             line_stall,
  input  logic             crc_pause_in,
  input  logic             crc_sending,
  output logic             crc_inb,
  output logic             crc_recving,
  output logic             crc_start,
  output logic             eop,
  output logic             pkt_done,
  output logic             pkt_err
);
  import usb_tx_pkg::*;

  localparam int EOP_W = (EOP_CYCLES < 2) ? 1 : $clog2(EOP_CYCLES + 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  logic             bit_inc, bit_clr;
  logic [2:0]       bit_cnt;
  logic             byte_inc, byte_clr;
  logic [LEN_W-1:0] byte_cnt;
  logic             eop_inc, eop_clr;
  logic [EOP_W-1:0] eop_cnt;

  logic adv;
  logic last_bit;
  logic bytes_left;

  counter #(.W(3)) u_bit_cnt (
    .clk     (clk),
    .rst_L   (rst_L),
    .inc_cnt (bit_inc),
    .clr_cnt (bit_clr),
    .up      (bit_cnt)
  );

  // Counts payload bytes already loaded into the shift register.
  counter #(.W(LEN_W)) u_byte_cnt (
    .clk     (clk),
    .rst_L   (rst_L),
    .inc_cnt (byte_inc),
    .clr_cnt (byte_clr),
    .up      (byte_cnt)
  );

  counter #(.W(EOP_W)) u_eop_cnt (
    .clk     (clk),
    .rst_L   (rst_L),
    .inc_cnt (eop_inc),
    .clr_cnt (eop_clr),
    .up      (eop_cnt)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pid_d       = pid_q;
    len_d       = len_q;
    err_d       = err_q;
    bit_inc     = 1'b0;
    bit_clr     = 1'b0;
    byte_inc    = 1'b0;
    byte_clr    = 1'b0;
    eop_inc     = 1'b0;
    eop_clr     = 1'b0;
    pkt_ready   = 1'b0;
    data_ready  = 1'b0;
    crc_inb     = 1'b0;
    crc_recving = 1'b0;
    crc_start   = 1'b0;
    eop         = 1'b0;
    pkt_done    = 1'b0;
    pkt_err     = 1'b0;

    adv        = ~line_stall;
    last_bit   = (bit_cnt == 3'd7);
    bytes_left = (byte_cnt != len_q);

    unique case (state_q)
      ST_IDLE: begin
        pkt_ready = ~crc_sending & ~crc_pause_in;
        if (pkt_valid && pkt_ready) begin
          pid_d    = pkt_pid;
          len_d    = pkt_len;
          bit_clr  = 1'b1;
          byte_clr = 1'b1;
          if (pkt_len > LEN_W'(MAX_BYTES)) begin
            err_d   = 1'b1;
            state_d = ST_REJECT;
          end else begin
            err_d   = 1'b0;
            shift_d = SYNC_BYTE;
            state_d = ST_SYNC;
          end
        end
      end

      ST_REJECT: begin
        state_d = ST_DONE;
      end

      ST_SYNC: begin
        crc_recving = 1'b1;
        crc_start   = 1'b1;
        crc_inb     = shift_q[0];
        if (adv) begin
          bit_inc = 1'b1;
          if (last_bit) begin
            shift_d = pid_byte(pid_q);
            state_d = ST_PID;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end

      ST_PID: begin
        crc_recving = 1'b1;
        crc_start   = 1'b1;
        crc_inb     = shift_q[0];
        if (adv) begin
          bit_inc = 1'b1;
          if (!last_bit) begin
            shift_d = {1'b0, shift_q[7:1]};
          end else if (len_q == '0) begin
            state_d = ST_WAITCRC;
          end else begin
            data_ready = 1'b1;
            if (data_valid) begin
              shift_d  = data_byte;
              byte_inc = 1'b1;
              state_d  = ST_DATA;
            end else begin
              err_d   = 1'b1;
              state_d = ST_WAITCRC;
            end
          end
        end
      end

      ST_DATA: begin
        crc_recving = 1'b1;
        crc_inb     = shift_q[0];
        if (adv) begin
          bit_inc = 1'b1;
          if (!last_bit) begin
            shift_d = {1'b0, shift_q[7:1]};
          end else if (!bytes_left) begin
            state_d = ST_WAITCRC;
          end else begin
            // Byte boundary: the next byte must be there now or the packet is cut short.
            data_ready = 1'b1;
            if (data_valid) begin
              shift_d  = data_byte;
              byte_inc = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_WAITCRC;
            end
          end
        end
      end

      ST_WAITCRC: begin
        if (!crc_sending) begin
          eop_clr = 1'b1;
          state_d = ST_EOP;
        end
      end

      ST_EOP: begin
        eop = 1'b1;
        if (eop_cnt == EOP_W'(EOP_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          eop_inc = 1'b1;
        end
      end

      ST_DONE: begin
        pkt_done = 1'b1;
        pkt_err  = err_q;
        err_d    = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs stay quiet for the whole reset cycle, even if the state was mid-packet.
    if (!rst_L) begin
      pkt_ready   = 1'b0;
      data_ready  = 1'b0;
      crc_inb     = 1'b0;
      crc_recving = 1'b0;
      crc_start   = 1'b0;
      eop         = 1'b0;
      pkt_done    = 1'b0;
      pkt_err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      pid_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_crc_tx_sequencer.sv
// Randomised packet traffic against a bit-stream model of the transmit sequencer,
// plus directed packets whose serial stream and timing are pinned to literals.
module tb_crc_tx_sequencer;
  import usb_tx_pkg::*;

  localparam int MAX_BYTES  = 64;
  localparam int EOP_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst_L, pkt_valid, data_valid, line_stall, crc_pause_in, crc_sending;
  logic [3:0] pkt_pid;
  logic [6:0] pkt_len;
  logic [7:0] data_byte;
  logic       pkt_ready, data_ready, crc_inb, crc_recving, crc_start, eop, pkt_done, pkt_err;

  always #5 clk = ~clk;

  crc_tx_sequencer #(.MAX_BYTES(MAX_BYTES), .LEN_W(7), .EOP_CYCLES(EOP_CYCLES)) dut (
    .clk(clk), .rst_L(rst_L), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_pid(pkt_pid), .pkt_len(pkt_len), .data_valid(data_valid), .data_ready(data_ready),
    .data_byte(data_byte), .line_stall(line_stall), .crc_pause_in(crc_pause_in),
    .crc_sending(crc_sending), .crc_inb(crc_inb), .crc_recving(crc_recving),
    .crc_start(crc_start), .eop(eop), .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  localparam int PH_IDLE = 0, PH_SEND = 1, PH_WAIT = 2, PH_EOP = 3, PH_DONE = 4, PH_REJ = 5;

  typedef struct packed { logic b; logic s; logic need; } bit_t;

  int   tests = 0, fails = 0;
  int   phase = PH_IDLE;
  bit_t bitq[$];

  logic       req = 1'b0;
  int         r_len, r_under;
  logic [3:0] r_pid;
  logic [7:0] r_pay [0:127];
  int         a_len = 0, a_under = -1;
  logic [7:0] a_pay [0:127];

  int   nb = 0, eop_left = 0, crc_tail = 0, tail_cfg = -1;
  logic err_m = 1'b0, fin = 1'b0;
  int   stall_mode = 0, stall_left = 0, sent_idx = 0, blip_en = 0;

  logic [63:0] cap;
  int   n_recv, n_start, n_eop, cyc = 0, acc_cyc, done_cyc;
  logic done_err;
  int   dr_idx[$];

  function automatic bit_t mk(input logic b, input logic s, input logic need);
    bit_t t;
    t.b = b; t.s = s; t.need = need;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare all outputs with the model, advance the model.
  task automatic cycle();
    logic [7:0] exp_o, act_o, pb, db, sb;
    bit_t h;
    @(negedge clk);
    cyc++;
    rst_L = 1'b1;
    line_stall = 1'b0;
    if (phase == PH_SEND) begin
      if (stall_mode == 1) line_stall = ($urandom_range(0, 3) == 0);
      else if (stall_mode == 2 && sent_idx == 20 && stall_left > 0) begin
        line_stall = 1'b1;
        stall_left--;
      end
    end
    if (phase == PH_SEND) data_valid = (nb < a_len) && (nb != a_under);
    else data_valid = 1'($urandom_range(0, 1));
    data_byte    = (phase == PH_SEND && nb < a_len) ? a_pay[nb] : 8'($urandom);
    crc_sending  = (crc_tail > 0);
    crc_pause_in = (crc_tail > 0) || (phase == PH_IDLE && blip_en != 0 && $urandom_range(0, 5) == 0);
    if (phase == PH_IDLE) begin
      pkt_valid = req; pkt_pid = r_pid; pkt_len = 7'(r_len);
    end else begin
      pkt_valid = 1'($urandom_range(0, 1)); pkt_pid = 4'($urandom); pkt_len = 7'($urandom);
    end
    #1;

    exp_o = '0;
    if (phase == PH_IDLE) exp_o[7] = !crc_sending && !crc_pause_in;
    if (phase == PH_SEND) begin
      h = bitq[0];
      exp_o[6] = h.need && !line_stall;
      exp_o[5] = h.b;
      exp_o[4] = 1'b1;
      exp_o[3] = h.s;
    end
    if (phase == PH_EOP) exp_o[2] = 1'b1;
    if (phase == PH_DONE) begin exp_o[1] = 1'b1; exp_o[0] = err_m; end
    act_o = {pkt_ready, data_ready, crc_inb, crc_recving, crc_start, eop, pkt_done, pkt_err};
    check("outputs{rdy,drdy,inb,recv,start,eop,done,err}", 64'(act_o), 64'(exp_o));

    if (crc_recving) n_recv++;
    if (crc_start) n_start++;
    if (eop) n_eop++;
    if (data_ready) dr_idx.push_back(sent_idx);
    if (crc_recving && !line_stall) cap = {cap[62:0], crc_inb};
    if (pkt_done) begin done_cyc = cyc; done_err = pkt_err; end

    if (crc_tail > 0) crc_tail--;
    case (phase)
      PH_IDLE: if (pkt_valid && exp_o[7]) begin
        acc_cyc = cyc; n_recv = 0; n_start = 0; n_eop = 0; cap = '0; dr_idx.delete();
        done_cyc = -1; done_err = 1'bx;
        a_len = r_len; a_pay = r_pay; a_under = r_under;
        nb = 0; sent_idx = 0; stall_left = 3; req = 1'b0;
        if (r_len > MAX_BYTES) begin
          err_m = 1'b1; phase = PH_REJ;
        end else begin
          err_m = 1'b0;
          sb = SYNC_BYTE;
          pb = {~r_pid, r_pid};
          for (int i = 0; i < 8; i++) bitq.push_back(mk(sb[i], 1'b1, 1'b0));
          for (int i = 0; i < 8; i++) bitq.push_back(mk(pb[i], 1'b1, (i == 7) && (r_len != 0)));
          phase = PH_SEND;
        end
      end
      PH_REJ: phase = PH_DONE;
      PH_SEND: if (!line_stall) begin
        h = bitq.pop_front();
        sent_idx++;
        if (h.need) begin
          if (data_valid) begin
            db = a_pay[nb];
            for (int i = 0; i < 8; i++) bitq.push_back(mk(db[i], 1'b0, (i == 7) && (nb + 1 < a_len)));
            nb++;
          end else begin
            err_m = 1'b1;
            bitq.delete();
          end
        end
        if (bitq.size() == 0) begin
          phase = PH_WAIT;
          crc_tail = (a_len == 0) ? 0 : (tail_cfg >= 0 ? tail_cfg : int'($urandom_range(0, 12)));
        end
      end
      PH_WAIT: if (!crc_sending) begin phase = PH_EOP; eop_left = EOP_CYCLES; end
      PH_EOP: begin eop_left--; if (eop_left == 0) phase = PH_DONE; end
      PH_DONE: begin phase = PH_IDLE; err_m = 1'b0; fin = 1'b1; end
      default: phase = PH_IDLE;
    endcase
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      rst_L = 1'b0; pkt_valid = 1'b1; data_valid = 1'b1; line_stall = 1'b0;
      crc_sending = 1'b0; crc_pause_in = 1'b0; pkt_pid = PID_ACK; pkt_len = 7'd1;
      data_byte = 8'hFF;
      #1;
      check("reset_outputs", 64'({pkt_ready, data_ready, crc_inb, crc_recving, crc_start, eop, pkt_done, pkt_err}), 64'd0);
    end
    phase = PH_IDLE; bitq.delete(); err_m = 1'b0; crc_tail = 0; req = 1'b0; nb = 0; a_len = 0;
  endtask

  task automatic set_req(input int len, input logic [3:0] pid, input int under);
    r_len = len; r_pid = pid; r_under = under;
    for (int i = 0; i < 128; i++) r_pay[i] = 8'($urandom);
    req = 1'b1; fin = 1'b0;
  endtask

  task automatic run_packet();
    for (int k = 0; k < 3000 && !fin; k++) cycle();
    if (!fin) begin
      tests++; fails++;
      $display("FAIL packet_timeout: got no pkt_done, required one within 3000 cycles");
      do_reset(2);
    end
  endtask

  initial begin
    rst_L = 1'b0; pkt_valid = 1'b0; data_valid = 1'b0; line_stall = 1'b0;
    crc_sending = 1'b0; crc_pause_in = 1'b0; pkt_pid = '0; pkt_len = '0; data_byte = '0;
    do_reset(3);

    // Reset in the middle of payload, then a clean ACK.
    stall_mode = 0; tail_cfg = 16; blip_en = 0;
    set_req(4, PID_DATA1, -1);
    for (int k = 0; k < 200 && sent_idx < 20; k++) cycle();
    check("reached_mid_data", 64'(phase), 64'(PH_SEND));
    do_reset(2);

    tail_cfg = 0;
    set_req(0, PID_ACK, -1);
    run_packet();
    check("ack_stream", cap[15:0], 64'h014B);
    check("ack_start_bits", 64'(n_start), 64'd16);
    check("ack_recv_bits", 64'(n_recv), 64'd16);
    check("ack_eop_cycles", 64'(n_eop), 64'd2);
    check("ack_done_latency", 64'(done_cyc - acc_cyc), 64'd20);
    check("ack_err", 64'(done_err), 64'd0);

    tail_cfg = 16;
    set_req(2, PID_DATA0, -1);
    r_pay[0] = 8'hA5; r_pay[1] = 8'h3C;
    run_packet();
    check("data0_stream", cap[31:0], 64'h01C3_A53C);
    check("data0_dready_count", 64'(dr_idx.size()), 64'd2);
    if (dr_idx.size() == 2) begin
      check("data0_dready_first", 64'(dr_idx[0]), 64'd15);
      check("data0_dready_second", 64'(dr_idx[1]), 64'd23);
    end
    check("data0_start_bits", 64'(n_start), 64'd16);
    check("data0_recv_bits", 64'(n_recv), 64'd32);
    check("data0_done_latency", 64'(done_cyc - acc_cyc), 64'd52);

    stall_mode = 2;
    set_req(2, PID_DATA0, -1);
    r_pay[0] = 8'hA5; r_pay[1] = 8'h3C;
    run_packet();
    check("stall_stream", cap[31:0], 64'h01C3_A53C);
    check("stall_recv_cycles", 64'(n_recv), 64'd35);
    check("stall_done_latency", 64'(done_cyc - acc_cyc), 64'd55);

    stall_mode = 0; tail_cfg = 0;
    set_req(3, PID_DATA1, 2);
    run_packet();
    check("underrun_recv_bits", 64'(n_recv), 64'd32);
    check("underrun_dready_count", 64'(dr_idx.size()), 64'd3);
    check("underrun_err", 64'(done_err), 64'd1);

    set_req(MAX_BYTES + 1, PID_DATA0, -1);
    run_packet();
    check("reject_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
    check("reject_err", 64'(done_err), 64'd1);
    check("reject_recv_bits", 64'(n_recv), 64'd0);

    // Random traffic: stalls, CRC tails, readiness blips, underruns and rejects.
    stall_mode = 1; tail_cfg = -1; blip_en = 1;
    for (int p = 0; p < 30; p++) begin
      int sel, len, under;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) len = int'($urandom_range(0, 5));
      else if (sel <= 7) len = int'($urandom_range(6, 12));
      else if (sel == 8) len = MAX_BYTES;
      else len = int'($urandom_range(MAX_BYTES + 1, 127));
      under = -1;
      if (len >= 2 && len <= MAX_BYTES && $urandom_range(0, 3) == 0) under = int'($urandom_range(1, len - 1));
      for (int g = 0, n = int'($urandom_range(0, 3)); g < n; g++) cycle();
      set_req(len, 4'($urandom), under);
      run_packet();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
